// File: rtl/fx2lp_pkg.sv
// rtl/fx2lp_pkg.sv - shared state encoding, FIFO addresses and flag indices for the FX2LP arbiter
package fx2lp_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_SETUP,
      ST_WR_LATCH,
      ST_WR_B0,
      ST_WR_B1,
      ST_WR_B2,
      ST_WR_B3,
      ST_RD_SETUP,
      ST_RD_DATA,
      ST_PKTEND
   } state_t;

   typedef enum logic {
      RR_WRITE = 1'b0,
      RR_READ  = 1'b1
   } rr_t;

   localparam logic [1:0] FIFOADR_EP2 = 2'b00;
   localparam logic [1:0] FIFOADR_EP6 = 2'b10;

   localparam int FLAG_EP2_EMPTY_N = 0;
   localparam int FLAG_EP6_FULL_N  = 1;

   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[8*idx +: 8];
   endfunction

endpackage

// File: rtl/fx2lp_pktend_timer.sv
// rtl/fx2lp_pktend_timer.sv - EP6 byte count modulo packet size and idle timer raising pktend_req
module fx2lp_pktend_timer #(
   parameter int PKT_BYTES    = 512,
   parameter int IDLE_TIMEOUT = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic word_done,
   input  logic in_idle,
   input  logic wr_req,
   input  logic pktend_done,
   output logic pktend_req
);

   localparam int CW = $clog2(PKT_BYTES);
   localparam int TW = $clog2(IDLE_TIMEOUT + 1);

   logic [CW-1:0] byte_count;
   logic [TW-1:0] idle_timer;

   // A full packet wraps the count to zero, so an auto-committed packet never arms the timer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_count <= '0;
         idle_timer <= '0;
      end else begin
         if (pktend_done)
            byte_count <= '0;
         else if (word_done)
            byte_count <= byte_count + CW'(4);

         if (pktend_done || word_done)
            idle_timer <= '0;
         else if (in_idle && (byte_count != '0) && !wr_req && (idle_timer != TW'(IDLE_TIMEOUT)))
            idle_timer <= idle_timer + 1'b1;
      end
   end

   assign pktend_req = (idle_timer == TW'(IDLE_TIMEOUT));

endmodule

// File: rtl/fx2lp_bus_arbiter.sv
// rtl/fx2lp_bus_arbiter.sv - round-robin owner of the FX2LP slave-FIFO bus for the IN (EP6) and OUT (EP2) streams
module fx2lp_bus_arbiter
   import fx2lp_pkg::*;
#(
   parameter int WR_BURST     = 8,
   parameter int RD_BURST     = 16,
   parameter int PKT_BYTES    = 512,
   parameter int IDLE_TIMEOUT = 4096
) (
   input  logic        csi_clk,
   input  logic        rsi_reset_n,
   input  logic [31:0] asi_in0_data,
   input  logic        asi_in0_valid,
   output logic        asi_in0_ready,
   output logic [7:0]  aso_out0_data,
   output logic        aso_out0_valid,
   input  logic        aso_out0_ready,
   output logic [7:0]  coe_fx2lp_fd_out,
   output logic        coe_fx2lp_fd_oe,
   input  logic [7:0]  coe_fx2lp_fd_in,
   input  logic [2:0]  coe_fx2lp_flag_n,
   output logic        coe_fx2lp_slrd_n,
   output logic        coe_fx2lp_slwr_n,
   output logic        coe_fx2lp_sloe_n,
   output logic [1:0]  coe_fx2lp_fifoadr,
   output logic        coe_fx2lp_pktend_n
);

   localparam int WCW = $clog2(WR_BURST + 1);
   localparam int RCW = $clog2(RD_BURST + 1);

   state_t         state, state_nx;
   rr_t            rr, rr_nx;
   logic [31:0]    word_reg;
   logic [WCW-1:0] wr_words;
   logic [RCW-1:0] rd_count;
   logic           wr_req, rd_req, slot_free, rd_fire, wr_accept, pktend_req;
   logic           flag_unused;

   assign flag_unused = coe_fx2lp_flag_n[2];

   assign wr_req    = asi_in0_valid & coe_fx2lp_flag_n[FLAG_EP6_FULL_N];
   assign rd_req    = coe_fx2lp_flag_n[FLAG_EP2_EMPTY_N] & ~aso_out0_valid;
   // The slot counts as free when its byte is being consumed this very cycle.
   assign slot_free = ~aso_out0_valid | aso_out0_ready;
   assign rd_fire   = (state == ST_RD_DATA) & coe_fx2lp_flag_n[FLAG_EP2_EMPTY_N] & slot_free
                      & (rd_count != RCW'(RD_BURST));
   assign wr_accept = (state == ST_WR_LATCH) & wr_req;

   always_comb begin
      state_nx           = state;
      rr_nx              = rr;
      asi_in0_ready      = 1'b0;
      coe_fx2lp_slrd_n   = 1'b1;
      coe_fx2lp_slwr_n   = 1'b1;
      coe_fx2lp_sloe_n   = 1'b1;
      coe_fx2lp_pktend_n = 1'b1;
      coe_fx2lp_fifoadr  = FIFOADR_EP6;
      coe_fx2lp_fd_oe    = 1'b0;
      coe_fx2lp_fd_out   = 8'h00;
      case (state)
         ST_IDLE: begin
            if (pktend_req) begin
               state_nx = ST_PKTEND;
            end else if (wr_req && (!rd_req || rr == RR_WRITE)) begin
               state_nx = ST_WR_SETUP;
               rr_nx    = RR_READ;
            end else if (rd_req) begin
               state_nx = ST_RD_SETUP;
               rr_nx    = RR_WRITE;
            end
         end
         ST_WR_SETUP: begin
            coe_fx2lp_fd_oe = 1'b1;
            state_nx        = ST_WR_LATCH;
         end
         ST_WR_LATCH: begin
            coe_fx2lp_fd_oe = 1'b1;
            if (wr_req) begin
               asi_in0_ready = 1'b1;
               state_nx      = ST_WR_B0;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_WR_B0: begin
            coe_fx2lp_fd_oe  = 1'b1;
            coe_fx2lp_slwr_n = 1'b0;
            coe_fx2lp_fd_out = word_byte(word_reg, 2'd0);
            state_nx         = ST_WR_B1;
         end
         ST_WR_B1: begin
            coe_fx2lp_fd_oe  = 1'b1;
            coe_fx2lp_slwr_n = 1'b0;
            coe_fx2lp_fd_out = word_byte(word_reg, 2'd1);
            state_nx         = ST_WR_B2;
         end
         ST_WR_B2: begin
            coe_fx2lp_fd_oe  = 1'b1;
            coe_fx2lp_slwr_n = 1'b0;
            coe_fx2lp_fd_out = word_byte(word_reg, 2'd2);
            state_nx         = ST_WR_B3;
         end
         ST_WR_B3: begin
            coe_fx2lp_fd_oe  = 1'b1;
            coe_fx2lp_slwr_n = 1'b0;
            coe_fx2lp_fd_out = word_byte(word_reg, 2'd3);
            // EP6 full is only honoured here, at the word boundary.
            if ((wr_words < WCW'(WR_BURST)) && coe_fx2lp_flag_n[FLAG_EP6_FULL_N])
               state_nx = ST_WR_LATCH;
            else
               state_nx = ST_IDLE;
         end
         ST_RD_SETUP: begin
            coe_fx2lp_fifoadr = FIFOADR_EP2;
            coe_fx2lp_sloe_n  = 1'b0;
            state_nx          = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            coe_fx2lp_fifoadr = FIFOADR_EP2;
            coe_fx2lp_sloe_n  = 1'b0;
            if (rd_fire)
               coe_fx2lp_slrd_n = 1'b0;
            else
               state_nx = ST_IDLE;
         end
         ST_PKTEND: begin
            coe_fx2lp_pktend_n = 1'b0;
            state_nx           = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         state          <= ST_IDLE;
         rr             <= RR_WRITE;
         word_reg       <= '0;
         wr_words       <= '0;
         rd_count       <= '0;
         aso_out0_data  <= '0;
         aso_out0_valid <= 1'b0;
      end else begin
         state <= state_nx;
         rr    <= rr_nx;
         if (wr_accept)
            word_reg <= asi_in0_data;
         if (state == ST_WR_SETUP)
            wr_words <= '0;
         else if (wr_accept)
            wr_words <= wr_words + 1'b1;
         if (state == ST_RD_SETUP)
            rd_count <= '0;
         else if (rd_fire)
            rd_count <= rd_count + 1'b1;
         if (rd_fire) begin
            aso_out0_data  <= coe_fx2lp_fd_in;
            aso_out0_valid <= 1'b1;
         end else if (aso_out0_valid && aso_out0_ready) begin
            aso_out0_valid <= 1'b0;
         end
      end
   end

   fx2lp_pktend_timer #(
      .PKT_BYTES    (PKT_BYTES),
      .IDLE_TIMEOUT (IDLE_TIMEOUT)
   ) u_pktend_timer (
      .clk         (csi_clk),
      .rst_n       (rsi_reset_n),
      .word_done   (state == ST_WR_B3),
      .in_idle     (state == ST_IDLE),
      .wr_req      (wr_req),
      .pktend_done (state == ST_PKTEND),
      .pktend_req  (pktend_req)
   );

endmodule
